// File: rtl/iz_neuron_scheduler_if.sv
// Handshake bundle between the neuron scheduler (master) and the shared
// Izhikevich update datapath (slave).
interface iz_neuron_scheduler_if;
    logic       dp_req;
    logic [7:0] dp_v;
    logic [7:0] dp_u;
    logic [2:0] dp_sel;
    logic [4:0] dp_i;
    logic       dp_ack;
    logic [7:0] dp_v_in;
    logic [7:0] dp_u_in;
    logic       dp_spike;

    modport master (
        output dp_req, dp_v, dp_u, dp_sel, dp_i,
        input  dp_ack, dp_v_in, dp_u_in, dp_spike
    );

    modport slave (
        input  dp_req, dp_v, dp_u, dp_sel, dp_i,
        output dp_ack, dp_v_in, dp_u_in, dp_spike
    );
endinterface

// File: rtl/iz_neuron_scheduler.sv
// Time-multiplexes N_NEURON virtual Izhikevich neurons onto one update datapath:
// one start walks every neuron through a request/ack exchange and writes the result back.
module iz_neuron_scheduler #(
    parameter int         N_NEURON = 4,
    parameter int         TIMEOUT  = 15,
    parameter logic [7:0] V_RESET  = 8'd0,
    parameter logic [7:0] U_RESET  = 8'd0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_addr,
    input  logic [2:0]                   cfg_sel,
    input  logic [4:0]                   cfg_i,
    iz_neuron_scheduler_if.master        dp,
    output logic                         busy,
    output logic                         done,
    output logic [N_NEURON-1:0]          spike_vec,
    output logic                         err,
    input  logic [1:0]                   mon_addr,
    output logic [7:0]                   mon_v,
    output logic [7:0]                   mon_u
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [N_NEURON-1:0]   shadow_q, shadow_d;
    logic [N_NEURON-1:0]   spike_q, spike_d;
    logic                  err_q, err_d;

    logic [7:0]            v_q   [N_NEURON];
    logic [7:0]            u_q   [N_NEURON];
    logic [2:0]            sel_q [N_NEURON];
    logic [4:0]            i_q   [N_NEURON];

    logic                  wb_en;
    logic                  cfg_en;
    logic                  advance;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        shadow_d = shadow_q;
        spike_d  = spike_q;
        err_d    = err_q;
        wb_en    = 1'b0;
        cfg_en   = 1'b0;
        advance  = 1'b0;
        done     = 1'b0;
        dp.dp_req = 1'b0;

        case (state_q)
            S_IDLE: begin
                cfg_en = cfg_we;
                if (start) begin
                    state_d  = S_REQ;
                    idx_d    = 2'd0;
                    wait_d   = '0;
                    err_d    = 1'b0;
                    shadow_d = '0;
                end
            end
            S_REQ: begin
                dp.dp_req = 1'b1;
                // An ack landing on the final wait cycle still counts as a response.
                if (dp.dp_ack) begin
                    wb_en            = 1'b1;
                    shadow_d[idx_q]  = dp.dp_spike;
                    advance          = 1'b1;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    shadow_d[idx_q]  = 1'b0;
                    err_d            = 1'b1;
                    advance          = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                if (advance) begin
                    state_d = (idx_q == 2'(N_NEURON - 1)) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                idx_d   = idx_q + 2'd1;
                wait_d  = '0;
                state_d = S_REQ;
            end
            S_DONE: begin
                done    = 1'b1;
                spike_d = shadow_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            wait_q   <= '0;
            shadow_q <= '0;
            spike_q  <= '0;
            err_q    <= 1'b0;
            for (int n = 0; n < N_NEURON; n++) begin
                v_q[n]   <= V_RESET;
                u_q[n]   <= U_RESET;
                sel_q[n] <= 3'd0;
                i_q[n]   <= 5'd0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            shadow_q <= shadow_d;
            spike_q  <= spike_d;
            err_q    <= err_d;
            if (wb_en) begin
                v_q[idx_q] <= dp.dp_v_in;
                u_q[idx_q] <= dp.dp_u_in;
            end
            if (cfg_en) begin
                sel_q[cfg_addr] <= cfg_sel;
                i_q[cfg_addr]   <= cfg_i;
            end
        end
    end

    // Operands come straight from storage; idx and the stored values cannot change while in REQ.
    assign dp.dp_v   = v_q[idx_q];
    assign dp.dp_u   = u_q[idx_q];
    assign dp.dp_sel = sel_q[idx_q];
    assign dp.dp_i   = i_q[idx_q];

    assign busy      = (state_q != S_IDLE);
    assign spike_vec = spike_q;
    assign err       = err_q;
    assign mon_v     = v_q[mon_addr];
    assign mon_u     = u_q[mon_addr];

endmodule

// File: tb/tb_iz_neuron_scheduler.sv
// Directed-plus-random bench for iz_neuron_scheduler: a per-neuron reference model
// predicts operands, writeback, spikes, timeouts and error flag for every sweep.
module tb_iz_neuron_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [2:0] cfg_sel;
    logic [4:0] cfg_i;
    logic       busy;
    logic       done;
    logic [3:0] spike_vec;
    logic       err;
    logic [1:0] mon_addr;
    logic [7:0] mon_v;
    logic [7:0] mon_u;

    iz_neuron_scheduler_if dpif ();

    iz_neuron_scheduler #(
        .N_NEURON (4),
        .TIMEOUT  (15),
        .V_RESET  (8'd0),
        .U_RESET  (8'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_sel   (cfg_sel),
        .cfg_i     (cfg_i),
        .dp        (dpif),
        .busy      (busy),
        .done      (done),
        .spike_vec (spike_vec),
        .err       (err),
        .mon_addr  (mon_addr),
        .mon_v     (mon_v),
        .mon_u     (mon_u)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model state
    logic [7:0] mv   [4];
    logic [7:0] mu   [4];
    logic [2:0] msel [4];
    logic [4:0] mi   [4];
    logic [3:0] mspk;
    logic [3:0] shadow;
    logic       merr;

    // Per-sweep stimulus: t_dly = REQ cycles before the ack; >= 15 means never ack
    int         t_dly [4];
    logic [7:0] t_vin [4];
    logic [7:0] t_uin [4];
    logic       t_sp  [4];
    bit         t_stray;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            mv[n] = 8'd0; mu[n] = 8'd0; msel[n] = 3'd0; mi[n] = 5'd0;
        end
        mspk = 4'd0; shadow = 4'd0; merr = 1'b0;
    endtask

    task automatic cfg(input int n, input logic [2:0] s, input logic [4:0] c);
        cfg_we = 1'b1; cfg_addr = 2'(n); cfg_sel = s; cfg_i = c;
        tick();
        cfg_we = 1'b0;
        msel[n] = s; mi[n] = c;
    endtask

    task automatic chk_store(input string tag);
        for (int n = 0; n < 4; n++) begin
            mon_addr = 2'(n);
            #1;
            chk($sformatf("%s_v%0d", tag, n), 32'(mon_v), 32'(mv[n]));
            chk($sformatf("%s_u%0d", tag, n), 32'(mon_u), 32'(mu[n]));
        end
    endtask

    task automatic clear_inputs();
        start = 1'b0; cfg_we = 1'b0;
        dpif.dp_ack = 1'b0; dpif.dp_spike = 1'b0;
    endtask

    task automatic sweep();
        int nreq;
        bit acked;
        shadow = 4'd0;
        merr   = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("err_clr", 32'(err), 0);
        chk("busy_run", 32'(busy), 1);
        for (int n = 0; n < 4; n++) begin
            acked = (t_dly[n] < 15);
            nreq  = acked ? t_dly[n] + 1 : 15;
            for (int c = 0; c < nreq; c++) begin
                chk($sformatf("req%0d_c%0d", n, c), 32'(dpif.dp_req), 1);
                if (c == 0) begin
                    chk($sformatf("dpv%0d", n), 32'(dpif.dp_v), 32'(mv[n]));
                    chk($sformatf("dpu%0d", n), 32'(dpif.dp_u), 32'(mu[n]));
                    chk($sformatf("dpsel%0d", n), 32'(dpif.dp_sel), 32'(msel[n]));
                    chk($sformatf("dpi%0d", n), 32'(dpif.dp_i), 32'(mi[n]));
                end else if (c == nreq - 1) begin
                    chk($sformatf("dpv_hold%0d", n), 32'(dpif.dp_v), 32'(mv[n]));
                end
                if (acked && c == t_dly[n]) begin
                    dpif.dp_ack = 1'b1; dpif.dp_v_in = t_vin[n];
                    dpif.dp_u_in = t_uin[n]; dpif.dp_spike = t_sp[n];
                end
                tick();
                dpif.dp_ack = 1'b0; dpif.dp_spike = 1'b0;
            end
            if (acked) begin
                mv[n] = t_vin[n]; mu[n] = t_uin[n]; shadow[n] = t_sp[n];
            end else begin
                shadow[n] = 1'b0; merr = 1'b1;
            end
            if (n < 3) begin
                chk($sformatf("gap_req%0d", n), 32'(dpif.dp_req), 0);
                chk($sformatf("gap_busy%0d", n), 32'(busy), 1);
                chk($sformatf("gap_done%0d", n), 32'(done), 0);
                if (t_stray) begin
                    dpif.dp_ack = 1'b1; dpif.dp_spike = 1'b1;
                    dpif.dp_v_in = 8'($urandom); dpif.dp_u_in = 8'($urandom);
                    start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'(n + 1);
                    cfg_sel = 3'($urandom); cfg_i = 5'($urandom);
                end
                tick();
                clear_inputs();
            end
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        mspk = shadow;
        tick();
        chk("done_low", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_req", 32'(dpif.dp_req), 0);
        chk("spike_vec", 32'(spike_vec), 32'(mspk));
        chk("err_flag", 32'(err), 32'(merr));
        tick();
        chk("no_resweep", 32'(busy), 0);
        chk("no_done2", 32'(done), 0);
        chk_store("st");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_sel = 3'd0;
        cfg_i = 5'd0; mon_addr = 2'd0;
        dpif.dp_ack = 1'b0; dpif.dp_v_in = 8'd0; dpif.dp_u_in = 8'd0; dpif.dp_spike = 1'b0;
        t_stray = 1'b0;
        model_reset();
        tick(); tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_req", 32'(dpif.dp_req), 0);
        chk("rst_spk", 32'(spike_vec), 0);
        chk("rst_err", 32'(err), 0);
        chk_store("rst");

        // Configured sweep, acks one cycle late, spike only on neuron 2
        for (int n = 0; n < 4; n++) begin
            cfg(n, 3'(n), 5'(n + 4));
            t_dly[n] = 1; t_vin[n] = 8'(8'h10 + n); t_uin[n] = 8'(8'h20 + n);
            t_sp[n] = (n == 2);
        end
        sweep();
        chk("spk_0100", 32'(spike_vec), 32'h4);

        // Minimum-latency sweep
        for (int n = 0; n < 4; n++) begin
            t_dly[n] = 0; t_vin[n] = 8'($urandom); t_uin[n] = 8'($urandom);
            t_sp[n] = 1'($urandom);
        end
        sweep();

        // Neuron 1 never answers
        for (int n = 0; n < 4; n++) begin
            t_dly[n] = (n == 1) ? 99 : 0; t_vin[n] = 8'($urandom);
            t_uin[n] = 8'($urandom); t_sp[n] = 1'b1;
        end
        sweep();
        chk("err_set", 32'(err), 1);
        chk("spk_bit1", 32'(spike_vec[1]), 0);

        // Ack coinciding with the last wait cycle on neuron 3; err must clear at start
        for (int n = 0; n < 4; n++) begin
            t_dly[n] = (n == 3) ? 14 : 0; t_vin[n] = 8'($urandom);
            t_uin[n] = 8'($urandom); t_sp[n] = 1'($urandom);
        end
        sweep();
        chk("tie_no_err", 32'(err), 0);

        // Stray start/cfg_we/dp_ack in every gap
        t_stray = 1'b1;
        for (int n = 0; n < 4; n++) begin
            t_dly[n] = 2; t_vin[n] = 8'($urandom); t_uin[n] = 8'($urandom);
            t_sp[n] = 1'($urandom);
        end
        sweep();

        // Random sweeps
        for (int k = 0; k < 6; k++) begin
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(0, 1) == 1) cfg(n, 3'($urandom), 5'($urandom));
                t_dly[n] = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 3));
                t_vin[n] = 8'($urandom); t_uin[n] = 8'($urandom); t_sp[n] = 1'($urandom);
            end
            t_stray = 1'($urandom);
            sweep();
        end
        t_stray = 1'b0;

        // Reset while neuron 2 is requesting, racing start/cfg_we/dp_ack
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("pre_req%0d", n), 32'(dpif.dp_req), 1);
            dpif.dp_ack = 1'b1; dpif.dp_v_in = 8'h5A; dpif.dp_u_in = 8'hA5;
            tick();
            dpif.dp_ack = 1'b0;
            tick();
        end
        chk("pre_req2", 32'(dpif.dp_req), 1);
        rst = 1'b1; start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd2; cfg_sel = 3'd7; cfg_i = 5'd31;
        dpif.dp_ack = 1'b1; dpif.dp_v_in = 8'hEE; dpif.dp_u_in = 8'hEE;
        tick();
        rst = 1'b0;
        clear_inputs();
        model_reset();
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_req", 32'(dpif.dp_req), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_spk", 32'(spike_vec), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_sel", 32'(dpif.dp_sel), 0);
        chk_store("mid_rst");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mid_rst_nodone%0d", c), 32'(done), 0);
        end

        // Normal sweep after the abort
        for (int n = 0; n < 4; n++) begin
            cfg(n, 3'(7 - n), 5'(n * 3));
            t_dly[n] = 1; t_vin[n] = 8'($urandom); t_uin[n] = 8'($urandom);
            t_sp[n] = 1'($urandom);
        end
        sweep();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/iz_neuron_scheduler.md
IZ_NEURON_SCHEDULER -- requirements
Module: iz_neuron_scheduler

Interface
REQ-001 Parameter N_NEURON, default 4: virtual neurons time-multiplexed onto one Izhikevich update datapath; index width 2 bits.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles waiting for dp_ack per neuron.
REQ-003 Parameters V_RESET and U_RESET, default 8'd0 each: reset value of every stored V and U.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request one sweep updating all N_NEURON neurons.
REQ-007 cfg_we  input  1  configuration write strobe.
REQ-008 cfg_addr  input  2  neuron index for the configuration write.
REQ-009 cfg_sel  input  3  neuron-type select stored for cfg_addr.
REQ-010 cfg_i  input  5  input current stored for cfg_addr.
REQ-011 dp_req  output  1  update request to the datapath.
REQ-012 dp_v, dp_u  output  8 each  stored V/U of the current neuron.
REQ-013 dp_sel  output  3; dp_i  output  5  stored select and current of the current neuron.
REQ-014 dp_ack  input  1  single-cycle pulse; dp_v_in, dp_u_in (8 each) and dp_spike valid in that cycle.
REQ-015 busy  output  1  sweep in progress; done  output  1  one-cycle end-of-sweep pulse.
REQ-016 spike_vec  output  N_NEURON  spikes from the last completed sweep, bit n = neuron n.
REQ-017 err  output  1  sticky timeout flag.
REQ-018 mon_addr  input  2; mon_v, mon_u  output  8 each  combinational read of stored V/U at mon_addr.

Function
REQ-019 States SHALL be IDLE, REQ, GAP, DONE; idx register selects the current neuron.
REQ-020 IDLE: start=1 SHALL move to REQ with idx=0 and clear err; otherwise stay.
REQ-021 REQ: dp_req=1; dp_v/dp_u/dp_sel/dp_i SHALL be driven from the storage of neuron idx and stay stable until leaving REQ.
REQ-022 REQ with dp_ack=1: write dp_v_in/dp_u_in into neuron idx, record dp_spike in shadow bit idx; go to DONE if idx=N_NEURON-1, else GAP.
REQ-023 REQ without ack for TIMEOUT consecutive cycles: neuron idx V/U unchanged, shadow bit idx=0, err set; same next-state rule as REQ-022.
REQ-024 dp_ack and the timeout in the same cycle: ack SHALL win; no err.
REQ-025 GAP: dp_req=0; idx incremented; next state REQ with the wait counter cleared.
REQ-026 DONE: done=1 for one cycle; spike_vec loaded from shadow; next state IDLE.
REQ-027 busy SHALL be 1 in REQ, GAP, DONE and 0 in IDLE.
REQ-028 start while busy SHALL be ignored; no queued sweep.
REQ-029 dp_ack outside REQ SHALL be ignored.
REQ-030 cfg_we in IDLE writes cfg_sel/cfg_i at cfg_addr next edge; cfg_we while busy SHALL be ignored.
REQ-031 Minimum sweep (immediate acks, N_NEURON=4): start sampled at cycle 0, REQ in cycles 1,3,5,7, done in cycle 8.
REQ-032 spike_vec and err SHALL hold between sweeps; shadow bits are cleared at sweep start.

Reset
REQ-033 rst=1 SHALL force IDLE, idx=0, wait counter 0, every V=V_RESET, U=U_RESET, sel=0, i=0, spike_vec=0, shadow=0, err=0, dp_req=0, busy=0, done=0.
REQ-034 rst asserted mid-sweep SHALL abort it with no done pulse and no further writeback; rst has priority over start, cfg_we, dp_ack.

Verification
REQ-035 Reset, then mon_addr 0..3 -> mon_v=mon_u=8'd0, busy=0, spike_vec=0.
REQ-036 cfg n: sel=n, i=5'd(n+4); start; model acks after 1 cycle with v_in=8'h10+n, u_in=8'h20+n, spike only for n=2 -> dp_sel/dp_i match per neuron, mon_v[n]=8'h10+n, spike_vec=4'b0100, one done pulse.
REQ-037 Immediate acks every REQ cycle -> dp_req high cycles 1,3,5,7, done cycle 8, busy low from cycle 9.
REQ-038 Withhold ack for neuron 1 -> dp_req held exactly 15 cycles, neuron 1 V/U unchanged, spike bit 1=0, err=1 after done; next start clears err.
REQ-039 start and cfg_we pulsed during a sweep, stray dp_ack in GAP -> no second sweep, cfg unchanged, no extra writeback.
REQ-040 rst during REQ of neuron 2 -> next cycle IDLE, all V=V_RESET, no done pulse; following sweep completes normally.
